// File: rtl/framebuffer_fill_scheduler.sv
// Framebuffer write-port owner: arbitrates a rectangle-fill engine against a
// single-pixel write stream, one registered write per clock.
module framebuffer_fill_scheduler #(
    parameter int LARGEUR = 320,
    parameter int HAUTEUR = 200,
    parameter int ADDR_W  = 16,
    parameter int COLOR_W = 24
) (
    input  logic               horloge,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [8:0]         cmd_x0,
    input  logic [7:0]         cmd_y0,
    input  logic [8:0]         cmd_w,
    input  logic [7:0]         cmd_h,
    input  logic [COLOR_W-1:0] cmd_couleur,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [8:0]         pix_x,
    input  logic [7:0]         pix_y,
    input  logic [COLOR_W-1:0] pix_couleur,
    output logic [ADDR_W-1:0]  addr,
    output logic [COLOR_W-1:0] dout,
    output logic               writeEnable,
    output logic               busy,
    output logic               fill_done
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [9:0]        LARG10 = 10'(LARGEUR);
    localparam logic [9:0]        HAUT10 = 10'(HAUTEUR);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(LARGEUR);

    state_t              state_q, state_d;
    logic                prio_fill_q, prio_fill_d;
    logic [9:0]          x_q, x_d, y_q, y_d;
    logic [9:0]          x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [COLOR_W-1:0]  color_q, color_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [COLOR_W-1:0]  dout_q, dout_d;
    logic                we_q, we_d;

    logic [9:0]          sum_x, sum_y;
    logic                cmd_empty, pix_fire, pix_in_range;
    logic [ADDR_W-1:0]   pix_addr;

    // 10-bit sums so an oversized rectangle clips instead of wrapping
    assign sum_x        = {1'b0, cmd_x0} + {1'b0, cmd_w};
    assign sum_y        = {2'b0, cmd_y0} + {2'b0, cmd_h};
    assign cmd_empty    = (cmd_w == 9'd0) || (cmd_h == 8'd0) ||
                          ({1'b0, cmd_x0} >= LARG10) || ({2'b0, cmd_y0} >= HAUT10);
    assign pix_in_range = ({1'b0, pix_x} < LARG10) && ({2'b0, pix_y} < HAUT10);
    assign pix_addr     = ADDR_W'(32'(pix_y) * 32'(LARGEUR) + 32'(pix_x));

    assign cmd_ready   = (state_q == IDLE);
    assign pix_ready   = !reset && ((state_q != FILL) || !prio_fill_q);
    assign pix_fire    = pix_valid && pix_ready;
    assign busy        = (state_q != IDLE);
    assign fill_done   = (state_q == DONE);
    assign addr        = addr_q;
    assign dout        = dout_q;
    assign writeEnable = we_q;

    always_comb begin
        state_d     = state_q;
        prio_fill_d = prio_fill_q;
        x_d         = x_q;
        y_d         = y_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        row_d       = row_q;
        color_d     = color_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        we_d        = 1'b0;

        // Out-of-screen pixels are consumed but never written
        if (pix_fire && pix_in_range) begin
            we_d   = 1'b1;
            addr_d = pix_addr;
            dout_d = pix_couleur;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    x0_d    = {1'b0, cmd_x0};
                    x_d     = {1'b0, cmd_x0};
                    y_d     = {2'b0, cmd_y0};
                    x1_d    = (sum_x > LARG10) ? LARG10 : sum_x;
                    y1_d    = (sum_y > HAUT10) ? HAUT10 : sum_y;
                    row_d   = ADDR_W'(32'(cmd_y0) * 32'(LARGEUR));
                    color_d = cmd_couleur;
                    state_d = cmd_empty ? DONE : FILL;
                end
            end
            FILL: begin
                if (pix_fire) begin
                    prio_fill_d = 1'b1;
                end else begin
                    prio_fill_d = 1'b0;
                    we_d        = 1'b1;
                    addr_d      = row_q + ADDR_W'(x_q);
                    dout_d      = color_q;
                    if (x_q + 10'd1 == x1_q) begin
                        x_d = x0_q;
                        if (y_q + 10'd1 == y1_q) begin
                            state_d = DONE;
                        end else begin
                            y_d   = y_q + 10'd1;
                            row_d = row_q + ROW_STEP;
                        end
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge horloge) begin
        if (reset) begin
            state_q     <= IDLE;
            prio_fill_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            row_q       <= '0;
            color_q     <= '0;
            addr_q      <= '0;
            dout_q      <= '0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_fill_q <= prio_fill_d;
            x_q         <= x_d;
            y_q         <= y_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            row_q       <= row_d;
            color_q     <= color_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            we_q        <= we_d;
        end
    end

endmodule

// File: tb/tb_framebuffer_fill_scheduler.sv
// Bench: table of fill commands, hand sequences for contention/reset corners,
// and randomized traffic checked every cycle against a queue-based write model.
module tb_framebuffer_fill_scheduler;

    localparam int W = 320;
    localparam int H = 200;

    logic        horloge = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [8:0]  cmd_x0 = '0;
    logic [7:0]  cmd_y0 = '0;
    logic [8:0]  cmd_w = '0;
    logic [7:0]  cmd_h = '0;
    logic [23:0] cmd_couleur = '0;
    logic        pix_valid = 1'b0;
    logic [8:0]  pix_x = '0;
    logic [7:0]  pix_y = '0;
    logic [23:0] pix_couleur = '0;
    logic        cmd_ready, pix_ready, writeEnable, busy, fill_done;
    logic [15:0] addr;
    logic [23:0] dout;

    framebuffer_fill_scheduler dut (
        .horloge(horloge), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_couleur(cmd_couleur),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_couleur(pix_couleur),
        .addr(addr), .dout(dout), .writeEnable(writeEnable),
        .busy(busy), .fill_done(fill_done)
    );

    always #5 horloge = ~horloge;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t",
                         name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: pending fill writes as a queue of (address, colour)
    typedef struct { int a; int c; } wr_t;
    wr_t fq[$];
    int  m_state = 0;   // 0 idle, 1 filling, 2 done-pulse
    bit  m_prio_fill = 0;

    int wr_cnt, first_addr, last_addr;

    // Called at a falling edge with inputs already set; ends at the next falling edge.
    task automatic step(input bit r);
        bit fire, e_pr, e_we, chk_ad;
        int e_addr, e_dout;
        reset = r;
        #1;
        e_pr = !r && (m_state != 1 || !m_prio_fill);
        if (!r) chk("cmd_ready", int'(cmd_ready), int'(m_state == 0));
        chk("pix_ready", int'(pix_ready), int'(e_pr));
        e_we = 0; e_addr = 0; e_dout = 0; chk_ad = 0;
        if (r) begin
            m_state = 0; m_prio_fill = 0; fq.delete(); chk_ad = 1;
        end else begin
            fire = pix_valid && e_pr;
            if (fire && pix_x < W && pix_y < H) begin
                e_we = 1; e_addr = int'(pix_y) * W + int'(pix_x); e_dout = int'(pix_couleur);
            end
            case (m_state)
                0: if (cmd_valid) begin
                    int xe, ye;
                    xe = int'(cmd_x0) + int'(cmd_w); if (xe > W) xe = W;
                    ye = int'(cmd_y0) + int'(cmd_h); if (ye > H) ye = H;
                    for (int y = int'(cmd_y0); y < ye; y++)
                        for (int x = int'(cmd_x0); x < xe; x++)
                            fq.push_back('{a: y * W + x, c: int'(cmd_couleur)});
                    m_state = (fq.size() > 0) ? 1 : 2;
                end
                1: if (fire) m_prio_fill = 1;
                   else begin
                       m_prio_fill = 0;
                       e_we = 1; e_addr = fq[0].a; e_dout = fq[0].c;
                       void'(fq.pop_front());
                       if (fq.size() == 0) m_state = 2;
                   end
                default: m_state = 0;
            endcase
            chk_ad = e_we;
        end
        @(negedge horloge);
        chk("writeEnable", int'(writeEnable), int'(e_we));
        if (chk_ad) begin
            chk("addr", int'(addr), e_addr);
            chk("dout", int'(dout), e_dout);
        end
        chk("busy", int'(busy), int'(m_state != 0));
        chk("fill_done", int'(fill_done), int'(m_state == 2));
        if (writeEnable === 1'b1) begin
            wr_cnt++;
            last_addr = int'(addr);
            if (first_addr < 0) first_addr = int'(addr);
        end
    endtask

    task automatic set_cmd(input int x0, input int y0, input int w, input int h, input int c);
        cmd_x0 = 9'(x0); cmd_y0 = 8'(y0); cmd_w = 9'(w); cmd_h = 8'(h); cmd_couleur = 24'(c);
    endtask

    // Issue one command with no pixel traffic and run it to fill_done
    task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                           input int c, input int budget);
        bit seen;
        set_cmd(x0, y0, w, h, c);
        pix_valid = 0; cmd_valid = 1;
        wr_cnt = 0; first_addr = -1; last_addr = -1;
        step(0);
        cmd_valid = 0;
        seen = fill_done;
        for (int i = 0; i < budget && !seen; i++) begin
            step(0);
            seen = fill_done;
        end
        chk("cmd_completes", int'(seen), 1);
        step(0);
    endtask

    typedef struct {
        int x0, y0, w, h, c;
        int n, first, last;
    } vec_t;
    vec_t vt[8];

    initial begin
        int hit_k, fill_cnt, done_cnt;

        vt[0] = '{0,   0,   320, 200, 'hFFFFFF, 64000, 0,     63999};
        vt[1] = '{318, 198, 5,   5,   'h00FF00, 4,     63678, 63999};
        vt[2] = '{5,   5,   0,   10,  'h111111, 0,     -1,    -1};
        vt[3] = '{320, 0,   5,   5,   'h222222, 0,     -1,    -1};
        vt[4] = '{0,   200, 1,   1,   'h333333, 0,     -1,    -1};
        vt[5] = '{10,  20,  1,   1,   'h444444, 1,     6410,  6410};
        vt[6] = '{300, 0,   30,  2,   'h555555, 40,    300,   639};
        vt[7] = '{0,   199, 320, 1,   'h666666, 320,   63680, 63999};

        @(negedge horloge);
        step(1);
        step(1);
        chk("rst_we", int'(writeEnable), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(fill_done), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);

        foreach (vt[i]) begin
            run_cmd(vt[i].x0, vt[i].y0, vt[i].w, vt[i].h, vt[i].c, 70000);
            chk($sformatf("vec%0d_count", i), wr_cnt, vt[i].n);
            chk($sformatf("vec%0d_first", i), first_addr, vt[i].first);
            chk($sformatf("vec%0d_last", i), last_addr, vt[i].last);
        end

        // Fill of row 0 contended by a held pixel request
        set_cmd(0, 0, 320, 1, 'h0000FF);
        cmd_valid = 1; step(0); cmd_valid = 0;
        pix_valid = 1; pix_x = 10; pix_y = 20; pix_couleur = 24'hFF0000;
        hit_k = -1; fill_cnt = 0; done_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            step(0);
            if (writeEnable && dout == 24'h0000FF) fill_cnt++;
            if (hit_k < 0 && writeEnable && addr == 16'd6410 && dout == 24'hFF0000) hit_k = k;
        end
        chk("t3_pix_within_2", int'(hit_k >= 1 && hit_k <= 2), 1);
        pix_valid = 0;
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            step(0);
            if (writeEnable && dout == 24'h0000FF) fill_cnt++;
            if (fill_done) done_cnt++;
        end
        chk("t3_fill_writes", fill_cnt, 320);
        step(0);

        // Out-of-screen pixels in IDLE
        pix_valid = 1; pix_x = 320; pix_y = 5; step(0);
        chk("t4_we_a", int'(writeEnable), 0);
        pix_x = 3; pix_y = 200; step(0);
        chk("t4_we_b", int'(writeEnable), 0);
        pix_valid = 0;

        // Reset at the 100th fill write
        set_cmd(0, 0, 320, 200, 'h123456);
        wr_cnt = 0; first_addr = -1;
        cmd_valid = 1; step(0); cmd_valid = 0;
        for (int k = 0; k < 200 && wr_cnt < 100; k++) step(0);
        chk("t5_reached_100", wr_cnt, 100);
        step(1);
        chk("t5_we", int'(writeEnable), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_cmd_ready", int'(cmd_ready), 1);
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(0);
            if (fill_done) done_cnt++;
        end
        chk("t5_no_done", done_cnt, 0);

        // Randomized mixed traffic
        for (int k = 0; k < 4000; k++) begin
            cmd_valid = ($urandom_range(0, 9) < 2);
            set_cmd($urandom_range(0, 340), $urandom_range(0, 210),
                    $urandom_range(0, 40), $urandom_range(0, 8), $urandom);
            pix_valid = ($urandom_range(0, 9) < 4);
            pix_x = 9'($urandom_range(0, 330));
            pix_y = 8'($urandom_range(0, 205));
            pix_couleur = 24'($urandom);
            step($urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
